coin_dispenser: RTL and testbench
=================================

Name: coin_dispenser

Overview:
- Change/coin output side of the drink vending path: the vending FSM accepts half/one coin pulses; this block pays coins back out.
- On a request it emits a sequence of half- and one-unit coins totalling a given amount, using a coin-hopper handshake.
- It tracks stock per coin type and reports insufficient-stock and hopper-timeout errors.

Parameters:
- AMT_W, 4: width of the amount field; units are half-coins (1 = half, 2 = one).
- STOCK_W, 6: width of each stock counter.
- HALF_INIT, 4: half-coin stock after reset.
- ONE_INIT, 4: one-coin stock after reset.
- ACK_TIMEOUT, 15: maximum number of cycles a drop waits for hop_ack.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- req  in  1  pay request pulse; sampled only in IDLE
- amount  in  AMT_W  amount to pay, in half-units; sampled with req
- hop_ack  in  1  hopper confirms the current coin was dropped
- refill_half  in  1  pulse: add one half coin to stock
- refill_one  in  1  pulse: add one one-coin to stock
- drop_half  out  1  level: hopper, drop one half coin
- drop_one  out  1  level: hopper, drop one one-coin
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse: payout complete
- err  out  1  1-cycle pulse: payout aborted
- err_code  out  2  00 none, 01 insufficient stock, 10 hopper timeout; held until next accepted req
- half_cnt  out  STOCK_W  current half-coin stock
- one_cnt  out  STOCK_W  current one-coin stock

Behaviour:
- Reset values: all outputs 0 except half_cnt=HALF_INIT and one_cnt=ONE_INIT; state IDLE; rem=0.
- States: IDLE, CHECK, GAP, DROP, DONE, FAULT.
- IDLE:
  - On req, latch amount into rem, clear err_code, go to CHECK.
  - req in any other state is ignored.
- CHECK (1 cycle):
  - n1 = min(rem>>1, one_cnt); n_half = rem - 2*n1.
  - rem==0: go to DONE.
  - n_half > half_cnt: err_code=01, go to FAULT. No coin is dropped.
  - Otherwise go to GAP.
- GAP (1 cycle, both drop lines low):
  - Select coin: one if rem>=2 and one_cnt>0, else half.
  - Clear the timeout counter, go to DROP.
- DROP:
  - Assert the selected drop line; hold it steady until hop_ack.
  - On hop_ack: deassert the line the next cycle. rem -= 2 (one) or 1 (half). Decrement the matching stock.
  - After hop_ack: rem becomes 0 -> DONE; otherwise -> GAP.
  - hop_ack while no drop line is asserted is ignored.
  - If the timeout counter reaches ACK_TIMEOUT cycles without ack: drop low, err_code=10, stock unchanged, go to FAULT. Coins already paid are not reverted.
- DONE: done=1 for one cycle, then IDLE.
- FAULT: err=1 for one cycle, then IDLE.
- Latency: req at cycle t -> CHECK t+1 -> GAP t+2 -> first drop line high t+3.
  - Each coin takes ack latency + 1 GAP cycle.
  - done is asserted the cycle after the last ack's DROP exit.
- Stock counters:
  - Refill and decrement in the same cycle are both applied (net 0).
  - Refill saturates at 2^STOCK_W-1.
  - Decrement never underflows; CHECK guarantees sufficiency because refills only add stock.
- Greedy selection after a passing CHECK always completes the payout with the available stock.
- drop_half and drop_one are never high together.
- Reset mid-operation: immediate return to reset values; stock counters reload their INIT values.

Decomposition:
- Shared package (drink_pkg):
  - State encoding localparams.
  - ERR_NONE=2'b00, ERR_STOCK=2'b01, ERR_TIMEOUT=2'b10.
  - Coin-value constants HALF_V=1, ONE_V=2, shared with the vending FSM.
- Sub-module coin_stock_counter:
  - Saturating up/down counter with INIT parameter, inc and dec inputs.
  - Instantiated twice, once for half coins and once for one-coins.

Test Plan:
- Reset with defaults, req amount=5, hop_ack 2 cycles after each drop:
  - Sequence one, one, half.
  - drop_one first high 3 cycles after req.
  - Exactly one done pulse.
  - one_cnt=2, half_cnt=3, err_code=00.
- Stock forced to one_cnt=0, half_cnt=4 (drain via payouts), req amount=3 -> three half drops, half_cnt=1, done.
- half_cnt=1, one_cnt=0, req amount=3:
  - err pulse 2 cycles after req, err_code=01.
  - No drop line ever high; stock unchanged.
- req amount=2, hop_ack never asserted:
  - drop_one high for exactly ACK_TIMEOUT cycles, then low.
  - err_code=10, one_cnt unchanged.
  - Next req amount=1 with ack completes normally and clears err_code.
- req amount=0 -> done 2 cycles after req, no drops.
- Robustness:
  - req pulses while busy are ignored.
  - refill_one asserted in the same cycle as a one-coin ack leaves one_cnt unchanged.
  - Reset asserted during DROP drives drop lines low immediately and reloads stock to 4/4.

Source files
------------

// File: rtl/drink_pkg.sv
// Shared constants for the drink vending path: coin values, error codes
// and the coin dispenser FSM state encoding.
package drink_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_GAP   = 3'd2;
   localparam logic [2:0] S_DROP  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_FAULT = 3'd5;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_STOCK   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam int HALF_V = 1;
   localparam int ONE_V  = 2;

   typedef enum logic {
      COIN_HALF = 1'b0,
      COIN_ONE  = 1'b1
   } coin_t;

endpackage

// File: rtl/coin_dispenser_if.sv
// Payout request/status and hopper handshake bundle.
// master: requester + hopper side; slave: coin_dispenser.
interface coin_dispenser_if #(
   parameter int AMT_W = 4
) ();

   logic             req;
   logic [AMT_W-1:0] amount;
   logic             hop_ack;
   logic             drop_half;
   logic             drop_one;
   logic             busy;
   logic             done;
   logic             err;
   logic [1:0]       err_code;

   modport master (
      output req, amount, hop_ack,
      input  drop_half, drop_one, busy, done, err, err_code
   );

   modport slave (
      input  req, amount, hop_ack,
      output drop_half, drop_one, busy, done, err, err_code
   );

endinterface

// File: rtl/coin_stock_counter.sv
// Stock counter for one coin type: reloads INIT on reset, saturating inc,
// non-underflowing dec. Ports: clk, reset, inc, dec, cnt.
module coin_stock_counter #(
   parameter int W    = 6,
   parameter int INIT = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] MAX = '1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= W'(INIT);
      end else if (inc && !dec) begin
         if (cnt != MAX) cnt <= cnt + W'(1);
      end else if (dec && !inc) begin
         if (cnt != '0) cnt <= cnt - W'(1);
      end
   end

endmodule

// File: rtl/coin_dispenser.sv
// Pays out an amount (half-coin units) as one/half coins via a hopper
// handshake. Ports: clk, reset, bus (slave), refill_*, half_cnt, one_cnt.
module coin_dispenser
   import drink_pkg::*;
#(
   parameter int AMT_W       = 4,
   parameter int STOCK_W     = 6,
   parameter int HALF_INIT   = 4,
   parameter int ONE_INIT    = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   coin_dispenser_if.slave    bus,
   input  logic               refill_half,
   input  logic               refill_one,
   output logic [STOCK_W-1:0] half_cnt,
   output logic [STOCK_W-1:0] one_cnt
);

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   localparam int CW   = ((AMT_W > STOCK_W) ? AMT_W : STOCK_W) + 2;

   logic [2:0]       state;
   logic [AMT_W-1:0] rem;
   coin_t            sel;
   logic [TO_W-1:0]  tcnt;
   logic [1:0]       err_code_q;

   logic [CW-1:0]    half_rem;
   logic [CW-1:0]    n1;
   logic [CW-1:0]    n_half;
   logic             short_stock;
   logic [AMT_W-1:0] coin_val;
   logic             ack_ok;
   logic             timed_out;
   coin_t            pick;

   // Use as many one-coins as stock allows; the rest must be halves.
   always_comb begin
      half_rem    = CW'(rem >> 1);
      n1          = (half_rem < CW'(one_cnt)) ? half_rem : CW'(one_cnt);
      n_half      = CW'(rem) - (n1 << 1);
      short_stock = n_half > CW'(half_cnt);
   end

   always_comb begin
      pick = COIN_HALF;
      unique case (1'b1)
         (rem >= AMT_W'(2)) && (one_cnt != '0): pick = COIN_ONE;
         default:                               pick = COIN_HALF;
      endcase
   end

   assign coin_val  = (sel == COIN_ONE) ? AMT_W'(ONE_V) : AMT_W'(HALF_V);
   assign ack_ok    = (state == S_DROP) && bus.hop_ack;
   assign timed_out = (state == S_DROP) && !bus.hop_ack &&
                      (tcnt == TO_W'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         rem        <= '0;
         sel        <= COIN_HALF;
         tcnt       <= '0;
         err_code_q <= ERR_NONE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.req) begin
                  rem        <= bus.amount;
                  err_code_q <= ERR_NONE;
                  state      <= S_CHECK;
               end
            end
            S_CHECK: begin
               unique case (1'b1)
                  (rem == '0): state <= S_DONE;
                  short_stock: begin
                     err_code_q <= ERR_STOCK;
                     state      <= S_FAULT;
                  end
                  default: state <= S_GAP;
               endcase
            end
            S_GAP: begin
               sel   <= pick;
               tcnt  <= '0;
               state <= S_DROP;
            end
            S_DROP: begin
               if (ack_ok) begin
                  rem   <= rem - coin_val;
                  state <= (rem == coin_val) ? S_DONE : S_GAP;
               end else if (timed_out) begin
                  err_code_q <= ERR_TIMEOUT;
                  state      <= S_FAULT;
               end else begin
                  tcnt <= tcnt + TO_W'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            S_FAULT: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.drop_one  = (state == S_DROP) && (sel == COIN_ONE);
   assign bus.drop_half = (state == S_DROP) && (sel == COIN_HALF);
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.err       = (state == S_FAULT);
   assign bus.err_code  = err_code_q;

   coin_stock_counter #(
      .W    (STOCK_W),
      .INIT (HALF_INIT)
   ) u_half (
      .clk   (clk),
      .reset (reset),
      .inc   (refill_half),
      .dec   (ack_ok && (sel == COIN_HALF)),
      .cnt   (half_cnt)
   );

   coin_stock_counter #(
      .W    (STOCK_W),
      .INIT (ONE_INIT)
   ) u_one (
      .clk   (clk),
      .reset (reset),
      .inc   (refill_one),
      .dec   (ack_ok && (sel == COIN_ONE)),
      .cnt   (one_cnt)
   );

endmodule

// File: tb/tb_coin_dispenser.sv
// Directed bench for coin_dispenser.
module tb_coin_dispenser;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       refill_half = 1'b0;
   logic       refill_one = 1'b0;
   logic [5:0] half_cnt;
   logic [5:0] one_cnt;

   int errors = 0;
   int checks = 0;
   int ovl = 0;

   coin_dispenser_if #(.AMT_W(4)) bus ();

   coin_dispenser dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .refill_half (refill_half),
      .refill_one  (refill_one),
      .half_cnt    (half_cnt),
      .one_cnt     (one_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.drop_half && bus.drop_one) ovl++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [3:0] amt);
      bus.req    = 1'b1;
      bus.amount = amt;
      step();
      bus.req    = 1'b0;
   endtask

   // Wait for a drop, check its type, ack 2 cycles later, check release.
   task automatic pay_coin(input string tag, input bit want_one);
      int n = 0;
      logic [1:0] want;
      want = want_one ? 2'b10 : 2'b01;
      while (!(bus.drop_half || bus.drop_one) && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_type"}, {bus.drop_one, bus.drop_half}, want);
      step();
      step();
      chk({tag, "_hold"}, {bus.drop_one, bus.drop_half}, want);
      bus.hop_ack = 1'b1;
      step();
      bus.hop_ack = 1'b0;
      chk({tag, "_rel"}, {bus.drop_one, bus.drop_half}, 2'b00);
   endtask

   task automatic end_done(input string tag);
      chk({tag, "_done"}, bus.done, 1'b1);
      step();
      chk({tag, "_idle"}, {bus.done, bus.busy}, 2'b00);
   endtask

   initial begin
      int n;
      bus.req     = 1'b0;
      bus.amount  = '0;
      bus.hop_ack = 1'b0;
      #2 reset = 1'b0;
      step();
      step();
      chk("rst_outs", {bus.busy, bus.done, bus.err, bus.err_code,
                       bus.drop_half, bus.drop_one}, 7'd0);
      chk("rst_stock", {half_cnt, one_cnt}, {6'd4, 6'd4});
      reset = 1'b1;
      step();

      // 5 half-units: one, one, half
      start(4'd5);
      step();
      step();
      chk("t1_lat", bus.drop_one, 1'b1);
      pay_coin("t1_c1", 1'b1);
      pay_coin("t1_c2", 1'b1);
      pay_coin("t1_c3", 1'b0);
      end_done("t1");
      chk("t1_stock", {half_cnt, one_cnt}, {6'd3, 6'd2});
      chk("t1_ec", bus.err_code, 2'b00);

      // drain one-coins, top up a half
      start(4'd4);
      pay_coin("t2a_c1", 1'b1);
      pay_coin("t2a_c2", 1'b1);
      end_done("t2a");
      refill_half = 1'b1;
      step();
      refill_half = 1'b0;
      chk("t2_pre", {half_cnt, one_cnt}, {6'd4, 6'd0});
      start(4'd3);
      pay_coin("t2_c1", 1'b0);
      pay_coin("t2_c2", 1'b0);
      pay_coin("t2_c3", 1'b0);
      end_done("t2");
      chk("t2_stock", {half_cnt, one_cnt}, {6'd1, 6'd0});

      // insufficient stock
      start(4'd3);
      chk("t3_chk_nodrop", {bus.drop_one, bus.drop_half}, 2'b00);
      step();
      chk("t3_err", {bus.err, bus.err_code}, 3'b101);
      chk("t3_nodrop", {bus.drop_one, bus.drop_half}, 2'b00);
      step();
      chk("t3_idle", {bus.err, bus.busy}, 2'b00);
      chk("t3_stock", {half_cnt, one_cnt}, {6'd1, 6'd0});
      chk("t3_ec_hold", bus.err_code, 2'b01);

      // hopper timeout
      refill_one = 1'b1;
      step();
      step();
      refill_one = 1'b0;
      chk("t4_pre", one_cnt, 6'd2);
      start(4'd2);
      step();
      step();
      n = 0;
      while (bus.drop_one && n < 40) begin
         n++;
         step();
      end
      chk("t4_len", n, 15);
      chk("t4_err", {bus.err, bus.err_code}, 3'b110);
      chk("t4_stock", one_cnt, 6'd2);
      step();
      start(4'd1);
      chk("t4b_ec_clr", bus.err_code, 2'b00);
      pay_coin("t4b_c1", 1'b0);
      end_done("t4b");
      chk("t4b_stock", {half_cnt, one_cnt}, {6'd0, 6'd2});

      // zero amount
      start(4'd0);
      chk("t5_busy", {bus.busy, bus.drop_one, bus.drop_half}, 3'b100);
      step();
      chk("t5_done", {bus.done, bus.drop_one, bus.drop_half}, 3'b100);
      step();
      chk("t5_idle", {bus.done, bus.busy}, 2'b00);

      // req while busy ignored; refill together with one-coin ack
      start(4'd2);
      bus.req    = 1'b1;
      bus.amount = 4'd4;
      step();
      bus.req = 1'b0;
      step();
      chk("t6_drop", bus.drop_one, 1'b1);
      step();
      step();
      bus.hop_ack = 1'b1;
      refill_one  = 1'b1;
      bus.req     = 1'b1;
      step();
      bus.hop_ack = 1'b0;
      refill_one  = 1'b0;
      bus.req     = 1'b0;
      chk("t6_done", bus.done, 1'b1);
      chk("t6_stock", one_cnt, 6'd2);
      step();
      step();
      chk("t6_ignored", bus.busy, 1'b0);

      // reset during DROP
      start(4'd2);
      step();
      step();
      chk("t7_drop", bus.drop_one, 1'b1);
      reset = 1'b0;
      #1;
      chk("t7_rst_drop", {bus.drop_one, bus.drop_half, bus.busy}, 3'b000);
      chk("t7_rst_stock", {half_cnt, one_cnt}, {6'd4, 6'd4});
      #3 reset = 1'b1;
      step();

      chk("no_overlap", ovl, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
